// File: rtl/press_count_display.sv
// -----------------------------------------------------------------------------
// press_count_display
//
// Counts button presses and shows the count on the board's 7-segment displays.
// Its input is the one-level-per-press `signal` from the button debouncer.
//
// Input path
//   `signal` is asynchronous to `clock`. It passes through a 2-FF synchroniser
//   (s1 -> s2) and then a delay register (s3). The rising-edge pulse is
//   inc = s2 & ~s3, so each low->high transition gives exactly one inc.
//
// Counter
//   A DIGITS-wide BCD up-counter with a ripple carry between digits.
//   By default the count wraps from all-9s to all-0s, and `wrap` pulses for the
//   one cycle in which that happens.
//
// Display
//   `hex` holds one registered 7-segment digit per BCD digit.
//   It is decoded from `bcd`, so it lags `bcd` by one cycle.
//
// Build option
//   SATURATE_EN (`ifdef): when defined, the count holds at all-9s and `wrap`
//   stays 0. `clear` and `reset` behave the same in both builds.
//
// Parameters
//   DIGITS          number of BCD digits (1..4)
//   SEG_ACTIVE_LOW  1: a lit segment is 0; 0: a lit segment is 1
//
// Ports
//   clock   in   1          system clock
//   reset   in   1          synchronous, active-high; has priority over all else
//   signal  in   1          debounced press level; asynchronous to clock
//   clear   in   1          synchronous count clear; beats a simultaneous inc
//   bcd     out  4*DIGITS   count; digit i at [4i+3:4i], digit 0 = units
//   hex     out  7*DIGITS   segments; digit i at [7i+6:7i], bit order g..a
//   wrap    out  1          one-cycle pulse when the count rolls max -> 0
// -----------------------------------------------------------------------------
module press_count_display #(
  parameter int DIGITS         = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  signal,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  wrap
);

  // Segment pattern for "0" in the selected polarity; used as the hex reset value.
  localparam logic [6:0] SEG_ZERO = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;

  logic                s1;
  logic                s2;
  logic                s3;
  logic                inc;
  logic [4*DIGITS-1:0] bcd_inc;
  logic                all_nines;
  logic                carry;
  logic [7*DIGITS-1:0] hex_next;

  // Active-low gfedcba code for one BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h7F;  // unreachable: digits never hold A..F
    endcase
    return code;
  endfunction

  // Synchroniser and edge-detect delay. These registers keep running while
  // clear is high, so a press whose inc is swallowed by clear is not replayed.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign inc = s2 & ~s3;

  // Ripple-carry BCD increment.
  // A digit at 9 with carry-in becomes 0 and passes the carry on.
  // At all-9s the result is all-0s.
  always_comb begin
    bcd_inc   = bcd;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd9) begin
        all_nines = 1'b0;
      end
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bcd  <= '0;
      wrap <= 1'b0;
    end else if (clear) begin
      bcd  <= '0;
      wrap <= 1'b0;
    end else if (inc && all_nines) begin
`ifdef SATURATE_EN
      bcd  <= bcd;
      wrap <= 1'b0;
`else
      bcd  <= '0;
      wrap <= 1'b1;
`endif
    end else if (inc) begin
      bcd  <= bcd_inc;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
    end
  end

  // Registered decode of the current count. Leading zeros are shown.
  always_comb begin
    hex_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (SEG_ACTIVE_LOW) begin
        hex_next[7*i +: 7] = seg_decode(bcd[4*i +: 4]);
      end else begin
        hex_next[7*i +: 7] = ~seg_decode(bcd[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hex <= {DIGITS{SEG_ZERO}};
    end else begin
      hex <= hex_next;
    end
  end

endmodule

// File: tb/tb_press_count_display.sv
// -----------------------------------------------------------------------------
// tb_press_count_display
//
// Bench for press_count_display with DIGITS = 2 and SEG_ACTIVE_LOW = 1.
//
// Reference model
//   The count is kept as a plain integer, m_count.
//   An inc happens at edge m when `signal` was sampled high at edge m-2 and
//   low at edge m-3. That is the stated latency: first high sample at k gives
//   a bcd update at k+2. Samples taken at or before a reset edge count as low.
//
// Expected outputs
//   bcd and hex are derived from m_count by decimal digit extraction and a
//   segment table. hex is the decode of the previous cycle's count.
//
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_press_count_display;

  localparam int DIGITS = 2;
  localparam int MAX    = 10**DIGITS - 1;
  localparam int W      = 1 + 7*DIGITS + 4*DIGITS;
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic                clock = 1'b0;
  logic                reset;
  logic                signal;
  logic                clear;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] hex;
  logic                wrap;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int                  m_count;
  logic                m_wrap;
  logic [7*DIGITS-1:0] m_hex;
  logic [3:0]          smp;  // smp[j] = signal sample from j edges ago
  logic [W-1:0]        exp_q[$];

  // ---------------------------------------------------------------------------
  // Clock and DUT
  // ---------------------------------------------------------------------------
  always #5 clock = ~clock;

  press_count_display #(.DIGITS(DIGITS), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock  (clock),
    .reset  (reset),
    .signal (signal),
    .clear  (clear),
    .bcd    (bcd),
    .hex    (hex),
    .wrap   (wrap)
  );

  // ---------------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------------
  function automatic logic [4*DIGITS-1:0] bcd_of(input int n);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] hex_of(input int n);
    logic [7*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = SEG[n % 10];
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_vec();
    return {m_wrap, m_hex, bcd_of(m_count)};
  endfunction

  // Advance one clock edge and update the model with the inputs seen there.
  task automatic step();
    logic inc;
    @(posedge clock);
    if (reset) begin
      smp     = '0;
      m_count = 0;
      m_wrap  = 1'b0;
      m_hex   = hex_of(0);
    end else begin
      smp    = {smp[2:0], signal};
      inc    = smp[2] & ~smp[3];
      m_hex  = hex_of(m_count);
      m_wrap = 1'b0;
      if (clear) begin
        m_count = 0;
      end else if (inc) begin
        if (m_count == MAX) begin
`ifndef SATURATE_EN
          m_count = 0;
          m_wrap  = 1'b1;
`endif
        end else begin
          m_count = m_count + 1;
        end
      end
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one press, high for hi cycles and then low for lo cycles.
  // Reports how many cycles disagreed with the model and how many wrap pulses
  // the DUT produced.
  // ---------------------------------------------------------------------------
  task automatic press(input int hi, input int lo, output int diffs, output int wraps);
    diffs  = 0;
    wraps  = 0;
    signal = 1'b1;
    for (int i = 0; i < hi + lo; i++) begin
      if (i == hi) signal = 1'b0;
      step();
      if ({wrap, hex, bcd} !== model_vec()) diffs++;
      if (wrap === 1'b1) wraps++;
    end
  endtask

  // Clear the count and then let the input pipeline drain.
  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (3) step();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset  = 1'b1;
    signal = 1'b0;
    clear  = 1'b0;
    step();
    step();
    reset = 1'b0;
    vectors++;
    if (bcd !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_bcd: got %h expected %h", bcd, 8'h00);
    end
    vectors++;
    if (hex !== {7'h40, 7'h40}) begin
      miscompares++;
      $display("FAIL reset_hex: got %h expected %h", hex, {7'h40, 7'h40});
    end
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wrap: got %b expected 0", wrap);
    end
  endtask

  task automatic test_hold_latency();
    signal = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      vectors++;
      if ({wrap, hex, bcd} !== model_vec()) begin
        miscompares++;
        $display("FAIL hold_model cyc %0d: got %h expected %h", i, {wrap, hex, bcd}, model_vec());
      end
      if (i == 2) begin
        vectors++;
        if (bcd !== 8'h00) begin
          miscompares++;
          $display("FAIL hold_early: got %h expected 00", bcd);
        end
      end
      if (i == 3) begin
        vectors++;
        if (hex !== {7'h40, 7'h40}) begin
          miscompares++;
          $display("FAIL hold_hex_lag: got %h expected %h", hex, {7'h40, 7'h40});
        end
      end
      if (i == 4) begin
        vectors++;
        if (hex !== {7'h40, 7'h79}) begin
          miscompares++;
          $display("FAIL hold_hex: got %h expected %h", hex, {7'h40, 7'h79});
        end
      end
      if (i >= 3) begin
        vectors++;
        if (bcd !== 8'h01) begin
          miscompares++;
          $display("FAIL hold_bcd cyc %0d: got %h expected 01", i, bcd);
        end
      end
    end
    signal = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_ten_presses();
    int diffs, wraps, total;
    do_clear();
    total = 0;
    for (int p = 0; p < 10; p++) begin
      press($urandom_range(4, 1), $urandom_range(4, 1), diffs, wraps);
      total += diffs;
    end
    press(0, 4, diffs, wraps);
    total += diffs;
    vectors++;
    if (total !== 0) begin
      miscompares++;
      $display("FAIL ten_model: got %0d bad cycles expected 0", total);
    end
    vectors++;
    if (bcd !== 8'h10) begin
      miscompares++;
      $display("FAIL ten_bcd: got %h expected 10", bcd);
    end
    vectors++;
    if (hex !== {7'h79, 7'h40}) begin
      miscompares++;
      $display("FAIL ten_hex: got %h expected %h", hex, {7'h79, 7'h40});
    end
  endtask

  task automatic test_wrap();
    int diffs, wraps, total, wtotal;
    do_clear();
    total  = 0;
    wtotal = 0;
    for (int p = 0; p < 99; p++) begin
      press(1, 1, diffs, wraps);
      total  += diffs;
      wtotal += wraps;
    end
    press(0, 4, diffs, wraps);
    total  += diffs;
    wtotal += wraps;
    vectors++;
    if (bcd !== 8'h99) begin
      miscompares++;
      $display("FAIL wrap_at99: got %h expected 99", bcd);
    end
    press(1, 5, diffs, wraps);
    total += diffs;
    vectors++;
    if (total !== 0) begin
      miscompares++;
      $display("FAIL wrap_model: got %0d bad cycles expected 0", total);
    end
`ifdef SATURATE_EN
    vectors++;
    if (bcd !== 8'h99) begin
      miscompares++;
      $display("FAIL sat_bcd: got %h expected 99", bcd);
    end
    vectors++;
    if (wtotal + wraps !== 0) begin
      miscompares++;
      $display("FAIL sat_wrap: got %0d pulses expected 0", wtotal + wraps);
    end
`else
    vectors++;
    if (bcd !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap_bcd: got %h expected 00", bcd);
    end
    vectors++;
    if (wraps !== 1 || wtotal !== 0) begin
      miscompares++;
      $display("FAIL wrap_pulse: got %0d/%0d pulses expected 0/1", wtotal, wraps);
    end
`endif
  endtask

  task automatic test_clear_collision();
    int diffs, wraps, total;
    do_clear();
    total = 0;
    for (int p = 0; p < 5; p++) begin
      press(2, 2, diffs, wraps);
      total += diffs;
    end
    press(0, 3, diffs, wraps);
    total += diffs;
    vectors++;
    if (bcd !== 8'h05) begin
      miscompares++;
      $display("FAIL clr_pre: got %h expected 05", bcd);
    end
    // The press's inc lands on the third edge after signal rises.
    signal = 1'b1;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++;
    if (bcd !== 8'h00 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_collide: got %h/%b expected 00/0", bcd, wrap);
    end
    press(6, 3, diffs, wraps);  // same press still held: must not be replayed
    total += diffs;
    vectors++;
    if (bcd !== 8'h00) begin
      miscompares++;
      $display("FAIL clr_replay: got %h expected 00", bcd);
    end
    press(2, 4, diffs, wraps);
    total += diffs;
    vectors++;
    if (bcd !== 8'h01) begin
      miscompares++;
      $display("FAIL clr_next: got %h expected 01", bcd);
    end
    vectors++;
    if (total !== 0) begin
      miscompares++;
      $display("FAIL clr_model: got %0d bad cycles expected 0", total);
    end
  endtask

  task automatic test_reset_mid();
    int diffs, wraps, total;
    do_clear();
    total = 0;
    for (int p = 0; p < 36; p++) begin
      press(1, 1, diffs, wraps);
      total += diffs;
    end
    signal = 1'b1;
    repeat (4) step();
    vectors++;
    if (bcd !== 8'h37) begin
      miscompares++;
      $display("FAIL rstmid_pre: got %h expected 37", bcd);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (bcd !== 8'h00 || hex !== {7'h40, 7'h40}) begin
      miscompares++;
      $display("FAIL rstmid_clr: got %h/%h expected 00/%h", bcd, hex, {7'h40, 7'h40});
    end
    // signal is still held, so exactly one inc follows once the pipeline refills.
    for (int i = 1; i <= 12; i++) begin
      step();
      vectors++;
      if ({wrap, hex, bcd} !== model_vec()) begin
        miscompares++;
        $display("FAIL rstmid_model cyc %0d: got %h expected %h", i, {wrap, hex, bcd}, model_vec());
      end
    end
    vectors++;
    if (bcd !== 8'h01) begin
      miscompares++;
      $display("FAIL rstmid_post: got %h expected 01", bcd);
    end
    vectors++;
    if (total !== 0) begin
      miscompares++;
      $display("FAIL rstmid_model_pre: got %0d bad cycles expected 0", total);
    end
    signal = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_v;
    int run;
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        signal = ~signal;
        run    = $urandom_range(signal ? 5 : 3, 1);
      end
      run--;
      clear = ($urandom_range(39, 0) == 0);
      reset = ($urandom_range(299, 0) == 0);
      step();
      exp_q.push_back(model_vec());
      exp_v = exp_q.pop_front();
      vectors++;
      if ({wrap, hex, bcd} !== exp_v) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h expected %h", i, {wrap, hex, bcd}, exp_v);
      end
    end
    reset = 1'b0;
    clear = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    reset  = 1'b1;
    signal = 1'b0;
    clear  = 1'b0;
    test_reset();
    test_hold_latency();
    test_ten_presses();
    test_wrap();
    test_clear_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
